fir_mac_seq: RTL
================

# fir_mac_seq

Parametrised successor to the two-tap first-difference filter: a TAPS-deep FIR with runtime-loadable signed coefficients, computed by one time-multiplexed multiply-accumulate unit. It sits in the same sample path (in_en/din in, out_en/dout out) and adds an output shift with saturation, a busy indication and overrun detection. Coefficients reset to the first-difference kernel, so a freshly reset block computes the same function as the block it replaces, with saturation instead of wrap.

## Interface
- DATA_W, 16: sample width, signed two's complement.
- COEF_W, 16: coefficient width, signed.
- TAPS, 8: filter length, 2..64.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation, 0..ACC_W-DATA_W.
- clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  DATA_W  input sample, signed.
- in_en  in  1  single-cycle sample strobe.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  tap index k (c[k] multiplies x[n-k]).
- coef_wdata  in  COEF_W  coefficient value, signed.
- overrun_clr  in  1  clears the overrun flag.
- dout  out  DATA_W  filtered sample, signed, held between strobes.
- out_en  out  1  one-cycle strobe marking a new dout.
- busy  out  1  high while in MAC state.
- overrun  out  1  sticky: a sample arrived while busy.

## Operation
- Reset (rst_n low, asynchronous): dout=0, out_en=0, busy=0, overrun=0, state IDLE, sample history x[0..TAPS-1]=0, accumulator=0, c[0]=+1, c[1]=-1, c[2..TAPS-1]=0.
- ACC_W = DATA_W+COEF_W+clog2(TAPS); full-precision signed products and sums, no intermediate truncation.
- y = sat_DATA_W(acc >>> SHIFT): arithmetic shift (rounds toward -inf), then clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- FSM states IDLE, MAC, OUT:
  - IDLE: in_en -> shift din into x[0] (history shifts by one, oldest dropped), acc<=0, tap counter<=0, go MAC.
  - MAC: each cycle acc += c[k]*x[k], k increments; after k=TAPS-1 go OUT.
  - OUT: dout<=y, out_en<=1 for one cycle; if in_en this cycle, accept sample exactly as in IDLE and go MAC, else go IDLE.
- in_en while in MAC: sample dropped, history untouched, overrun<=1. overrun_clr clears it; if set and clear coincide, set wins.
- coef_we applies only in IDLE or OUT; ignored in MAC (the in-flight result never mixes old and new coefficients). Writes take effect for the next accepted sample.

## Timing
- Sample accepted on edge E0; MACs on E1..E_TAPS; dout/out_en registered on E_(TAPS+1). Latency in_en -> out_en = TAPS+1 cycles.
- Peak throughput: one sample per TAPS+1 cycles (in_en in OUT cycle accepted back-to-back).
- busy high from the cycle after E0 through the cycle after E_(TAPS-1) (TAPS cycles); low in IDLE and OUT.
- out_en never high two consecutive cycles.
- Reset asserted mid-MAC: computation abandoned, no out_en after release; first in_en after release starts from zeroed history.

## Structure
- Package fir_pkg: state enum (IDLE, MAC, OUT), ACC_W derivation function, default difference-kernel constant.
- One sub-module fir_sat: combinational shift-and-saturate, parameters ACC_W, DATA_W, SHIFT; instantiated once on the accumulator output.
- Coefficients and history as register arrays, single shared multiplier.

## Test plan
- Reset defaults, TAPS=8: din 100 then 300 (strobes spaced 9 cycles) -> dout 100 then 200, each out_en exactly 9 cycles after its in_en.
- Saturation: din 32767 then -32768 -> second dout = -32768 (not wrapped); din -32768 then 32767 -> 32767.
- Coefficient load: all c[k]=1, SHIFT=3, constant din 800 -> dout ramps 100,200,...,800 and holds 800 from the 8th output.
- Overrun: in_en at E0 and E0+3 -> second sample dropped, overrun=1, first output correct; overrun_clr same cycle as new overrun -> overrun stays 1.
- coef_we during MAC (c[0]=5) -> ignored, output unchanged; same write in IDLE -> next output uses 5.
- rst_n low at E0+4 -> dout=0, out_en=0, coefficients back to {+1,-1,0,...}, no out_en within 20 cycles after release.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and helpers for the sequential multiply-accumulate FIR.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_e;

  // Accumulator wide enough that TAPS full-precision products can never overflow.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // First-difference kernel: y[n] = x[n] - x[n-1].
  function automatic int diff_kernel(input int k);
    return (k == 0) ? 1 : ((k == 1) ? -1 : 0);
  endfunction

endpackage

// File: rtl/fir_mac_seq_if.sv
// Sample path, coefficient port and status of the sequential FIR.
interface fir_mac_seq_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8
);
  localparam int AW = $clog2(TAPS);

  // Strobe semantics, no back-pressure: in_en is a one-cycle sample strobe that
  // the filter takes in IDLE or OUT and drops (flagging overrun) while busy;
  // out_en is a one-cycle strobe qualifying dout, which holds between strobes.
  logic signed [DATA_W-1:0] din;
  logic                     in_en;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     overrun_clr;
  logic signed [DATA_W-1:0] dout;
  logic                     out_en;
  logic                     busy;
  logic                     overrun;

  modport master (
    output din, in_en, coef_we, coef_addr, coef_wdata, overrun_clr,
    input  dout, out_en, busy, overrun
  );

  modport slave (
    input  din, in_en, coef_we, coef_addr, coef_wdata, overrun_clr,
    output dout, out_en, busy, overrun
  );

endinterface

// File: rtl/fir_sat.sv
// Arithmetic right shift of the accumulator followed by clamp to DATA_W signed.
module fir_sat #(
  parameter int ACC_W  = 35,
  parameter int DATA_W = 16,
  parameter int SHIFT  = 0
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y
);

  logic signed [ACC_W-1:0]      shifted;
  logic        [ACC_W-DATA_W:0] upper;
  logic                         in_range;

  assign shifted  = acc >>> SHIFT;
  // Representable exactly when every bit above the DATA_W sign bit copies it.
  assign upper    = shifted[ACC_W-1:DATA_W-1];
  assign in_range = (&upper) | ~(|upper);

  always_comb begin
    y = shifted[DATA_W-1:0];
    if (!in_range) begin
      if (shifted[ACC_W-1]) y = {1'b1, {(DATA_W-1){1'b0}}};
      else                  y = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fir_mac_seq.sv
// TAPS-deep FIR with loadable coefficients, one shared multiplier stepped over
// the taps, saturating output and overrun detection.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int SHIFT  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  fir_mac_seq_if.slave  bus,
  output fir_state_e    state
);

  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  logic signed [DATA_W-1:0] hist [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [AW-1:0]            k;
  logic signed [PW-1:0]     prod;
  logic signed [DATA_W-1:0] y;
  logic signed [DATA_W-1:0] dout_q;
  logic                     out_en_q;
  logic                     busy_q;
  logic                     overrun_q;
  logic                     accept;

  assign prod   = PW'(coef[k]) * PW'(hist[k]);
  assign accept = bus.in_en && (state != MAC);

  fir_sat #(.ACC_W(ACC_W), .DATA_W(DATA_W), .SHIFT(SHIFT)) u_sat (
    .acc (acc),
    .y   (y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      k         <= '0;
      dout_q    <= '0;
      out_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= COEF_W'(diff_kernel(i));
      end
    end else begin
      out_en_q <= 1'b0;
      if (bus.overrun_clr) overrun_q <= 1'b0;

      // Coefficients are frozen while a result is being accumulated.
      if (bus.coef_we && state != MAC) coef[bus.coef_addr] <= bus.coef_wdata;

      if (accept) begin
        hist[0] <= bus.din;
        for (int i = 1; i < TAPS; i++) hist[i] <= hist[i-1];
        acc <= '0;
        k   <= '0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            state  <= MAC;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          if (bus.in_en) overrun_q <= 1'b1;
          if (k == LAST) begin
            busy_q <= 1'b0;
            state  <= OUT;
          end else begin
            k <= k + AW'(1);
          end
        end
        OUT: begin
          dout_q   <= y;
          out_en_q <= 1'b1;
          if (accept) begin
            busy_q <= 1'b1;
            state  <= MAC;
          end else begin
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dout    = dout_q;
  assign bus.out_en  = out_en_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule
